// File: rtl/eth_rx_length_framer.sv
// eth_rx_length_framer
// Pairs each received-length entry with its RX AXI-Stream frame and emits a
// length-prefixed frame: a 2-byte big-endian byte count, then the payload.
// The output byte count always comes from the length entry. A frame whose beat
// count disagrees with its entry is cut short or ended early, and it is flagged
// through m_axis_tuser on its last beat. An entry whose byte count exceeds
// MAX_FRAME_LEN causes its frame to be drained silently.

module eth_rx_length_framer #(
  parameter int LEN_WIDTH     = 11,
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst_n,
  // length entry stream: value = frame byte count - 1
  input  logic [LEN_WIDTH-1:0] s_len_tdata,
  input  logic                 s_len_tvalid,
  output logic                 s_len_tready,
  // RX frame byte stream
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  // length-prefixed output stream
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  // per-frame status pulses
  output logic                 stat_frame_ok,
  output logic                 stat_len_mismatch,
  output logic                 stat_len_reject
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,     // waiting for a length entry
    ST_HDR_HI,   // emit byte count [15:8]
    ST_HDR_LO,   // emit byte count [7:0]
    ST_PAYLOAD,  // forward frame bytes, counting against the entry
    ST_DRAIN     // discard frame bytes up to and including tlast
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] frame_len_q, frame_len_d;   // byte count taken from the entry
  logic [15:0] remaining_q, remaining_d;   // payload bytes still owed

  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic        m_tuser_q, m_tuser_d;

  logic        stat_ok_q, stat_ok_d;
  logic        stat_mis_q, stat_mis_d;
  logic        stat_rej_q, stat_rej_d;

  logic        load_en;
  logic        len_accept;
  logic        axis_accept;
  logic [15:0] len_n;

  // The output register may be written when it is empty or is being drained
  // this cycle.
  assign load_en     = !m_tvalid_q || m_axis_tready;
  assign len_accept  = s_len_tvalid && s_len_tready;
  assign axis_accept = s_axis_tvalid && s_axis_tready;
  // The entry holds bytes-1. Widening the entry to 16 bits first lets the
  // increment carry past LEN_WIDTH.
  assign len_n       = 16'(s_len_tdata) + 16'd1;

  // Input handshakes. The input side stays closed until a length entry has
  // been accepted, so an unmatched frame waits upstream.
  always_comb begin
    s_len_tready  = (state_q == ST_IDLE);
    s_axis_tready = ((state_q == ST_PAYLOAD) && load_en) || (state_q == ST_DRAIN);
  end

  // Next-state logic, output-register loading and status-pulse generation.
  always_comb begin
    // NOTE: every variable assigned here gets a default first; a path that skips an assignment would otherwise infer a latch.
    state_d     = state_q;
    frame_len_d = frame_len_q;
    remaining_d = remaining_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    // A presented beat that is taken downstream empties the register unless it is reloaded.
    m_tvalid_d  = m_tvalid_q && !m_axis_tready;
    stat_ok_d   = 1'b0;
    stat_mis_d  = 1'b0;
    stat_rej_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (len_accept) begin
          if (len_n > MAX_LEN) begin
            stat_rej_d = 1'b1;
            state_d    = ST_DRAIN;
          end else begin
            frame_len_d = len_n;
            remaining_d = len_n;
            state_d     = ST_HDR_HI;
          end
        end
      end

      ST_HDR_HI: begin
        if (load_en) begin
          m_tdata_d  = frame_len_q[15:8];
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          m_tuser_d  = 1'b0;
          state_d    = ST_HDR_LO;
        end
      end

      ST_HDR_LO: begin
        if (load_en) begin
          m_tdata_d  = frame_len_q[7:0];
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          m_tuser_d  = 1'b0;
          state_d    = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (axis_accept) begin
          m_tdata_d   = s_axis_tdata;
          m_tvalid_d  = 1'b1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            // The byte count is satisfied. If the input frame ends here too,
            // the frame is good. Otherwise the output is ended here and the
            // extra input bytes are discarded.
            m_tlast_d = 1'b1;
            if (s_axis_tlast) begin
              m_tuser_d = 1'b0;
              stat_ok_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              m_tuser_d  = 1'b1;
              stat_mis_d = 1'b1;
              state_d    = ST_DRAIN;
            end
          end else if (s_axis_tlast) begin
            // The input frame ended before its byte count was reached.
            m_tlast_d  = 1'b1;
            m_tuser_d  = 1'b1;
            stat_mis_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            m_tlast_d = 1'b0;
            m_tuser_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (axis_accept && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register. An asynchronous reset abandons any frame in progress.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Counters, output register and status pulses. All are cleared by reset, so
  // no partial frame can leave the block after reset is released.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      frame_len_q <= '0;
      remaining_q <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      stat_ok_q   <= 1'b0;
      stat_mis_q  <= 1'b0;
      stat_rej_q  <= 1'b0;
    end else begin
      frame_len_q <= frame_len_d;
      remaining_q <= remaining_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
      stat_ok_q   <= stat_ok_d;
      stat_mis_q  <= stat_mis_d;
      stat_rej_q  <= stat_rej_d;
    end
  end

  assign m_axis_tdata      = m_tdata_q;
  assign m_axis_tvalid     = m_tvalid_q;
  assign m_axis_tlast      = m_tlast_q;
  assign m_axis_tuser      = m_tuser_q;
  assign stat_frame_ok     = stat_ok_q;
  assign stat_len_mismatch = stat_mis_q;
  assign stat_len_reject   = stat_rej_q;

endmodule

// File: tb/tb_eth_rx_length_framer.sv
// Testbench for eth_rx_length_framer.
// Stimulus is queued to two free-running drivers (length entries, frame bytes).
// A frame-level model pushes the expected output beats and status totals, and
// a monitor pops and compares every beat the DUT hands downstream.

module tb_eth_rx_length_framer;

  localparam int LEN_WIDTH     = 11;
  localparam int MAX_FRAME_LEN = 1522;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } out_beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } in_beat_t;

  logic                 logic_clk;
  logic                 logic_rst_n;
  logic [LEN_WIDTH-1:0] s_len_tdata;
  logic                 s_len_tvalid;
  logic                 s_len_tready;
  logic [7:0]           s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 s_axis_tlast;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic                 m_axis_tuser;
  logic                 stat_frame_ok;
  logic                 stat_len_mismatch;
  logic                 stat_len_reject;

  eth_rx_length_framer #(
    .LEN_WIDTH    (LEN_WIDTH),
    .MAX_FRAME_LEN(MAX_FRAME_LEN)
  ) dut (
    .logic_clk        (logic_clk),
    .logic_rst_n      (logic_rst_n),
    .s_len_tdata      (s_len_tdata),
    .s_len_tvalid     (s_len_tvalid),
    .s_len_tready     (s_len_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .stat_frame_ok    (stat_frame_ok),
    .stat_len_mismatch(stat_len_mismatch),
    .stat_len_reject  (stat_len_reject)
  );

  // Stimulus, scoreboard and bookkeeping
  logic [LEN_WIDTH-1:0] len_drv_q[$];
  in_beat_t             ax_drv_q[$];
  out_beat_t            sb_q[$];

  int checks   = 0;
  int failures = 0;
  int exp_ok   = 0, exp_mis = 0, exp_rej = 0;
  int obs_ok   = 0, obs_mis = 0, obs_rej = 0;
  int ax_acc   = 0;
  bit rand_ready = 0;
  bit gaps_en    = 0;

  initial begin
    logic_clk = 1'b0;
    forever #5 logic_clk = ~logic_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model. It queues one length entry and one input
  // frame, and it pushes the output the framer must produce for that pair.
  task automatic gen_frame(input int len_entry, input int nbytes, input bit incr,
                           input bit push_len, input bit expect_out);
    logic [7:0] bytes[$];
    int n, k;
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] d;
      d = incr ? 8'(i) : 8'($urandom);
      bytes.push_back(d);
      ax_drv_q.push_back('{data: d, last: (i == nbytes - 1)});
    end
    if (push_len) len_drv_q.push_back(LEN_WIDTH'(len_entry));
    if (!expect_out) return;
    n = len_entry + 1;
    if (n > MAX_FRAME_LEN) begin
      exp_rej++;
      return;
    end
    sb_q.push_back('{data: 8'(n >> 8), last: 1'b0, user: 1'b0});
    sb_q.push_back('{data: 8'(n), last: 1'b0, user: 1'b0});
    k = (nbytes < n) ? nbytes : n;
    for (int i = 0; i < k; i++)
      sb_q.push_back('{data: bytes[i], last: (i == k - 1), user: (i == k - 1) && (nbytes != n)});
    if (nbytes == n) exp_ok++;
    else exp_mis++;
  endtask

  // Length entry driver
  initial begin
    s_len_tvalid = 1'b0;
    s_len_tdata  = '0;
    forever begin
      if (!logic_rst_n) begin
        len_drv_q.delete();
        s_len_tvalid = 1'b0;
        @(posedge logic_clk); #1;
      end else if (len_drv_q.size() == 0 || (gaps_en && $urandom_range(0, 3) == 0)) begin
        s_len_tvalid = 1'b0;
        @(posedge logic_clk); #1;
      end else begin
        s_len_tvalid = 1'b1;
        s_len_tdata  = len_drv_q[0];
        @(negedge logic_clk);
        if (logic_rst_n && s_len_tready) begin
          @(posedge logic_clk); #1;
          if (logic_rst_n) void'(len_drv_q.pop_front());
        end else begin
          @(posedge logic_clk); #1;
        end
      end
    end
  end

  // Frame byte driver
  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    forever begin
      if (!logic_rst_n) begin
        ax_drv_q.delete();
        s_axis_tvalid = 1'b0;
        @(posedge logic_clk); #1;
      end else if (ax_drv_q.size() == 0 || (gaps_en && $urandom_range(0, 3) == 0)) begin
        s_axis_tvalid = 1'b0;
        @(posedge logic_clk); #1;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = ax_drv_q[0].data;
        s_axis_tlast  = ax_drv_q[0].last;
        @(negedge logic_clk);
        if (logic_rst_n && s_axis_tready) begin
          @(posedge logic_clk); #1;
          if (logic_rst_n) begin
            void'(ax_drv_q.pop_front());
            ax_acc++;
          end
        end else begin
          @(posedge logic_clk); #1;
        end
      end
    end
  end

  // Downstream ready: either always ready, or ready on roughly half the cycles
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge logic_clk); #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares handed-off beats, checks stability while stalled, and
  // tallies status pulses
  initial begin
    bit        stall;
    out_beat_t held, cur, exp;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge logic_clk);
      if (!logic_rst_n) begin
        stall = 1'b0;
      end else begin
        obs_ok  += int'(stat_frame_ok);
        obs_mis += int'(stat_len_mismatch);
        obs_rej += int'(stat_len_reject);
        cur = '{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser};
        if (stall) begin
          check("stall_valid_hold", 32'(m_axis_tvalid), 32'd1);
          check("stall_beat_hold", 32'(cur), 32'(held));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data=0x%0h last=%0b user=%0b with nothing expected at %0t",
                     cur.data, cur.last, cur.user, $time);
          end else begin
            exp = sb_q.pop_front();
            check("out_beat{data,last,user}", 32'(cur), 32'(exp));
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        held  = cur;
      end
    end
  end

  // Waits until everything queued has been consumed and emitted, then checks
  // the status totals
  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((len_drv_q.size() != 0 || ax_drv_q.size() != 0 || sb_q.size() != 0 || m_axis_tvalid)
           && n < budget) begin
      @(negedge logic_clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, sb_q.size(), n);
    end
    repeat (3) @(negedge logic_clk);
    check({name, "_stat_frame_ok"}, 32'(obs_ok), 32'(exp_ok));
    check({name, "_stat_len_mismatch"}, 32'(obs_mis), 32'(exp_mis));
    check({name, "_stat_len_reject"}, 32'(obs_rej), 32'(exp_rej));
  endtask

  // Watchdog: any hang still ends with a FAIL line and the summary line
  initial begin
    #950000;
    failures++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base, n;
    logic_rst_n = 1'b0;
    repeat (4) @(posedge logic_clk);
    #1;
    check("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("reset_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("reset_m_tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
    check("reset_stats", 32'({stat_frame_ok, stat_len_mismatch, stat_len_reject}), 32'd0);
    check("reset_s_axis_tready", 32'(s_axis_tready), 32'd0);
    check("reset_s_len_tready", 32'(s_len_tready), 32'd1);
    logic_rst_n = 1'b1;
    repeat (2) @(posedge logic_clk);
    #1;

    // A frame with no length entry is never accepted
    gen_frame(7, 8, 1'b1, 1'b0, 1'b1);
    repeat (12) begin
      @(negedge logic_clk);
      check("no_len_s_axis_tready", 32'(s_axis_tready), 32'd0);
    end
    check("no_len_bytes_accepted", 32'(ax_acc), 32'd0);
    len_drv_q.push_back(LEN_WIDTH'(7));
    wait_done("idle_wait", 200);

    // Exact-length frame: 64 incrementing bytes
    gen_frame(63, 64, 1'b1, 1'b1, 1'b1);
    wait_done("t1_exact", 500);

    // Short frame: entry says 100 bytes, 60 arrive
    gen_frame(99, 60, 1'b1, 1'b1, 1'b1);
    wait_done("t2_short", 500);

    // Long frame: entry says 64 bytes, 80 arrive; the next frame must be clean
    gen_frame(63, 80, 1'b1, 1'b1, 1'b1);
    gen_frame(20, 21, 1'b0, 1'b1, 1'b1);
    wait_done("t3_long", 800);

    // Oversize entry is rejected and drained; boundary 1522 accepted, 1523 rejected
    gen_frame(1999, 2000, 1'b0, 1'b1, 1'b1);
    gen_frame(40, 41, 1'b0, 1'b1, 1'b1);
    gen_frame(MAX_FRAME_LEN - 1, MAX_FRAME_LEN, 1'b0, 1'b1, 1'b1);
    gen_frame(MAX_FRAME_LEN, MAX_FRAME_LEN + 1, 1'b0, 1'b1, 1'b1);
    gen_frame(0, 1, 1'b0, 1'b1, 1'b1);
    wait_done("t4_reject", 8000);

    // Back-to-back random frames with random downstream stalls and input gaps
    rand_ready = 1'b1;
    gaps_en    = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int len_entry, nb, sel;
      len_entry = $urandom_range(63, 1521);
      sel = $urandom_range(0, 4);
      if (sel == 0)      nb = len_entry + 1 - $urandom_range(1, 40);
      else if (sel == 1) nb = len_entry + 1 + $urandom_range(1, 40);
      else               nb = len_entry + 1;
      gen_frame(len_entry, nb, 1'b0, 1'b1, 1'b1);
    end
    wait_done("t5_random", 80000);
    rand_ready = 1'b0;
    gaps_en    = 1'b0;
    repeat (2) @(posedge logic_clk);
    #1;

    // Reset while payload byte 30 is presented
    base = ax_acc;
    gen_frame(99, 100, 1'b1, 1'b1, 1'b0);
    sb_q.push_back('{data: 8'h00, last: 1'b0, user: 1'b0});
    sb_q.push_back('{data: 8'h64, last: 1'b0, user: 1'b0});
    for (int i = 0; i < 30; i++) sb_q.push_back('{data: 8'(i), last: 1'b0, user: 1'b0});
    n = 0;
    while (ax_acc != base + 30 && n < 500) begin
      @(negedge logic_clk);
      n++;
    end
    check("t6_reached_byte30", 32'(ax_acc - base), 32'd30);
    #2;
    logic_rst_n = 1'b0;
    #1;
    check("t6_async_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_async_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("t6_async_m_tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
    check("t6_async_stats", 32'({stat_frame_ok, stat_len_mismatch, stat_len_reject}), 32'd0);
    check("t6_async_s_axis_tready", 32'(s_axis_tready), 32'd0);
    check("t6_prefix_beats_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    repeat (3) @(posedge logic_clk);
    #1;
    logic_rst_n = 1'b1;
    repeat (3) @(posedge logic_clk);
    #1;
    gen_frame(31, 32, 1'b0, 1'b1, 1'b1);
    wait_done("t6_after_reset", 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
